meas_wr_arbiter: RTL and testbench

Shares the single regfile write port among the five `measure` channels. Each channel's one-cycle write pulse is captured into a per-channel holding slot. A round-robin scheduler drains the slots one per clock into the regfile. Simultaneous or back-to-back results are never lost silently: each slot either drains or raises a sticky overflow flag. The block sits between the `measure` array and `regfile`, replacing the one-hot write mux.

---
 rtl/meas_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 36 +++
 rtl/meas_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_meas_wr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/meas_arb_pkg.sv
// Shared constants and types for the measure-channel regfile write arbiter.
//   CHAN_NUM    : number of measure channels feeding the arbiter
//   DATA_W      : width of one measurement result
//   CHAN_W      : width of a channel index
//   chan_idx_t  : channel index type
//   meas_data_t : measurement result type
package meas_arb_pkg;

  localparam int CHAN_NUM = 5;
  localparam int DATA_W   = 64;
  localparam int CHAN_W   = $clog2(CHAN_NUM);

  typedef logic [CHAN_W-1:0] chan_idx_t;
  typedef logic [DATA_W-1:0] meas_data_t;

endpackage : meas_arb_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker. It searches the request vector starting
// one position after the previous winner and wraps from N-1 back to 0.
// Ports:
//   req     : request vector, one bit per requester
//   last    : index of the previous winner
//   gnt_vld : at least one request is present
//   gnt_idx : index of the winning requester (0 when gnt_vld is low)
module rr_picker #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  int cand;

  // Walk the N candidates in priority order; the first requester found wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule : rr_picker

// File: rtl/meas_wr_arbiter.sv
// Shares the single regfile write port among the measure channels. Each
// one-cycle write pulse is parked in a per-channel slot; a round-robin
// scheduler drains one slot per clock. A pulse that finds its slot occupied
// and not draining is dropped and flagged in a sticky overflow bit.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   raw_wr_en_i    : per-channel write pulses
//   raw_wr_data_i  : per-channel results, valid with their pulse
//   clr_ovf_i      : synchronous clear of all overflow flags
//   reg_wr_en_o    : regfile write strobe
//   reg_wr_data_o  : regfile write data (holds when idle)
//   reg_wr_chan_o  : channel index of the write (holds when idle)
//   pend_o         : slot-occupied flags
//   ovf_o          : sticky overflow flags
//   busy_o         : at least one slot occupied
module meas_wr_arbiter #(
  parameter int CHAN_NUM = meas_arb_pkg::CHAN_NUM,
  parameter int DATA_W   = meas_arb_pkg::DATA_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CHAN_NUM-1:0]              raw_wr_en_i,
  input  logic [CHAN_NUM-1:0][DATA_W-1:0]  raw_wr_data_i,
  input  logic                             clr_ovf_i,
  output logic                             reg_wr_en_o,
  output logic [DATA_W-1:0]                reg_wr_data_o,
  output logic [$clog2(CHAN_NUM)-1:0]      reg_wr_chan_o,
  output logic [CHAN_NUM-1:0]              pend_o,
  output logic [CHAN_NUM-1:0]              ovf_o,
  output logic                             busy_o
);

  localparam int IDX_W = $clog2(CHAN_NUM);

  logic [CHAN_NUM-1:0] pend;
  logic [CHAN_NUM-1:0] pend_nxt;
  logic [CHAN_NUM-1:0] ovf;
  logic [CHAN_NUM-1:0] ovf_nxt;
  logic [CHAN_NUM-1:0] load;
  logic [CHAN_NUM-1:0] drain;
  logic [DATA_W-1:0]   slot_data [CHAN_NUM];
  logic [IDX_W-1:0]    last;
  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;

  rr_picker #(
    .N     (CHAN_NUM),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (pend),
    .last    (last),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Per-slot capture / drain / overflow decisions.
  always_comb begin
    pend_nxt = pend;
    ovf_nxt  = ovf;
    load     = '0;
    drain    = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      drain[i] = gnt_vld && (gnt_idx == IDX_W'(i));
      // A slot draining this cycle counts as free, so a new pulse re-arms it.
      if (raw_wr_en_i[i] && (!pend[i] || drain[i])) begin
        load[i]     = 1'b1;
        pend_nxt[i] = 1'b1;
      end else if (drain[i]) begin
        pend_nxt[i] = 1'b0;
      end else begin
        pend_nxt[i] = pend[i];
      end
      // Set has priority over clear when both hit in the same cycle.
      if (raw_wr_en_i[i] && pend[i] && !drain[i]) begin
        ovf_nxt[i] = 1'b1;
      end else if (clr_ovf_i) begin
        ovf_nxt[i] = 1'b0;
      end else begin
        ovf_nxt[i] = ovf[i];
      end
    end
  end

  // Slot data registers; a dropped pulse leaves the old value untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHAN_NUM; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHAN_NUM; i++) begin
        if (load[i]) begin
          slot_data[i] <= raw_wr_data_i[i];
        end else begin
          slot_data[i] <= slot_data[i];
        end
      end
    end
  end

  // Scheduler state and registered regfile-side outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend          <= '0;
      ovf           <= '0;
      busy_o        <= 1'b0;
      last          <= IDX_W'(CHAN_NUM - 1);
      reg_wr_en_o   <= 1'b0;
      reg_wr_data_o <= '0;
      reg_wr_chan_o <= '0;
    end else begin
      pend   <= pend_nxt;
      ovf    <= ovf_nxt;
      busy_o <= |pend_nxt;
      if (gnt_vld) begin
        reg_wr_en_o   <= 1'b1;
        reg_wr_data_o <= slot_data[gnt_idx];
        reg_wr_chan_o <= gnt_idx;
        last          <= gnt_idx;
      end else begin
        // Data and index keep their last values while idle.
        reg_wr_en_o <= 1'b0;
      end
    end
  end

  assign pend_o = pend;
  assign ovf_o  = ovf;

endmodule : meas_wr_arbiter

// File: tb/tb_meas_wr_arbiter.sv
// Scoreboard bench for meas_wr_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every regfile write.
module tb_meas_wr_arbiter;

  localparam int CN = 5;
  localparam int DW = 64;

  typedef struct packed {
    logic [2:0]    chan;
    logic [DW-1:0] data;
  } exp_t;

  logic                   clk;
  logic                   rst_i;
  logic [CN-1:0]          raw_wr_en;
  logic [CN-1:0][DW-1:0]  raw_wr_data;
  logic                   clr_ovf;
  logic                   reg_wr_en;
  logic [DW-1:0]          reg_wr_data;
  logic [2:0]             reg_wr_chan;
  logic [CN-1:0]          pend;
  logic [CN-1:0]          ovf;
  logic                   busy;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt [8];
  int   c0;
  int   c3;

  meas_wr_arbiter #(.CHAN_NUM(CN), .DATA_W(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .raw_wr_en_i   (raw_wr_en),
    .raw_wr_data_i (raw_wr_data),
    .clr_ovf_i     (clr_ovf),
    .reg_wr_en_o   (reg_wr_en),
    .reg_wr_data_o (reg_wr_data),
    .reg_wr_chan_o (reg_wr_chan),
    .pend_o        (pend),
    .ovf_o         (ovf),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic [63:0] d);
    exp_t e;
    e.chan = ch;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tick(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},   64'(reg_wr_en),   64'd0);
    check({tag, "_data"}, reg_wr_data,      64'd0);
    check({tag, "_chan"}, 64'(reg_wr_chan), 64'd0);
    check({tag, "_pend"}, 64'(pend),        64'd0);
    check({tag, "_ovf"},  64'(ovf),         64'd0);
    check({tag, "_busy"}, 64'(busy),        64'd0);
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  initial begin
    exp_t e;
    for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_i && reg_wr_en) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got chan=%0d data=%h expected no write", reg_wr_chan, reg_wr_data);
        end else begin
          e = q.pop_front();
          check("wr_chan", 64'(reg_wr_chan), 64'(e.chan));
          check("wr_data", reg_wr_data, e.data);
        end
        total++;
        if (reg_wr_data == 64'hBEEF) begin
          bad++;
          $display("FAIL dropped_data_written: got %h expected never 000000000000beef", reg_wr_data);
        end
        wr_cnt[reg_wr_chan]++;
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    raw_wr_en   = '0;
    raw_wr_data = '0;
    clr_ovf     = 1'b0;

    // Reset state, during and just after reset.
    tick(2);
    check_idle_outputs("rst");
    rst_i = 1'b0;
    tick(1);
    check_idle_outputs("post_rst");

    // Single channel on an idle bus.
    raw_wr_en      = 5'b00100;
    raw_wr_data[2] = 64'h1234;
    push(3'd2, 64'h1234);
    tick(1);
    raw_wr_en = '0;
    check("single_busy_t1", 64'(busy), 64'd1);
    check("single_pend_t1", 64'(pend), 64'h04);
    check("single_en_t1",   64'(reg_wr_en), 64'd0);
    tick(1);
    check("single_en_t2",   64'(reg_wr_en), 64'd1);
    check("single_chan_t2", 64'(reg_wr_chan), 64'd2);
    check("single_data_t2", reg_wr_data, 64'h1234);
    check("single_busy_t2", 64'(busy), 64'd0);
    tick(2);
    check("single_idle_en", 64'(reg_wr_en), 64'd0);
    check("single_hold_data", reg_wr_data, 64'h1234);

    // All five simultaneously after reset: order 0..4 in consecutive cycles.
    do_reset();
    for (int i = 0; i < CN; i++) begin
      raw_wr_data[i] = 64'hA0 + 64'(i);
      push(3'(i), 64'hA0 + 64'(i));
    end
    raw_wr_en = 5'b11111;
    tick(1);
    raw_wr_en = '0;
    for (int k = 0; k < CN; k++) begin
      tick(1);
      check("all5_en", 64'(reg_wr_en), 64'd1);
      check("all5_chan", 64'(reg_wr_chan), 64'(k));
    end
    tick(1);
    check("all5_done_en", 64'(reg_wr_en), 64'd0);
    check("all5_ovf", 64'(ovf), 64'd0);

    // Overflow: channel 4 pulses again while still waiting.
    do_reset();
    for (int i = 0; i < CN; i++) begin
      raw_wr_data[i] = 64'hC0 + 64'(i);
      push(3'(i), 64'hC0 + 64'(i));
    end
    raw_wr_en = 5'b11111;
    tick(1);
    raw_wr_en      = 5'b10000;
    raw_wr_data[4] = 64'hBEEF;
    tick(1);
    raw_wr_en = '0;
    check("ovf_set_early", 64'(ovf), 64'h10);
    tick(6);
    check("ovf_sticky", 64'(ovf), 64'h10);
    check("ovf_pend_empty", 64'(pend), 64'd0);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);

    // Re-arm on grant: new pulse lands in the cycle channel 1 drains.
    raw_wr_en      = 5'b00010;
    raw_wr_data[1] = 64'h11;
    push(3'd1, 64'h11);
    tick(1);
    raw_wr_data[1] = 64'h55;
    push(3'd1, 64'h55);
    tick(1);
    raw_wr_en = '0;
    check("rearm_pend_held", 64'(pend), 64'h02);
    tick(3);
    check("rearm_ovf", 64'(ovf), 64'd0);
    check("rearm_pend_empty", 64'(pend), 64'd0);

    // Fairness: channels 0 and 3 pulse every other cycle; grants alternate 3,0.
    c0 = wr_cnt[0];
    c3 = wr_cnt[3];
    for (int k = 0; k < 10; k++) begin
      raw_wr_en      = 5'b01001;
      raw_wr_data[0] = 64'h100 + 64'(k);
      raw_wr_data[3] = 64'h300 + 64'(k);
      push(3'd3, 64'h300 + 64'(k));
      push(3'd0, 64'h100 + 64'(k));
      tick(1);
      raw_wr_en = '0;
      tick(1);
    end
    tick(4);
    check("fair_cnt0", 64'(wr_cnt[0] - c0), 64'd10);
    check("fair_cnt3", 64'(wr_cnt[3] - c3), 64'd10);
    check("fair_ovf", 64'(ovf), 64'd0);

    // Reset mid-drain with three slots pending.
    raw_wr_en      = 5'b10101;
    raw_wr_data[0] = 64'hD0;
    raw_wr_data[2] = 64'hD2;
    raw_wr_data[4] = 64'hD4;
    tick(1);
    raw_wr_en = '0;
    #1;
    check("middrain_pend", 64'(pend), 64'h15);
    rst_i = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    tick(2);
    rst_i = 1'b0;
    tick(8);
    check("after_rst_pend", 64'(pend), 64'd0);
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_meas_wr_arbiter
